pc_sequencer: RTL and testbench

// Run-control sequencer for one CGRA column program counter. Takes a kernel start

---
 rtl/pc_sequencer.sv | 168 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Run-control sequencer for one CGRA column program counter.
// Accepts a kernel start, drives the PC counter controls, arbitrates RC branch
// requests (lowest index wins), honours memory stalls, drains the RC pipeline
// after EXIT and reports completion or abort back to the CGRA controller.
//
// Handshake semantics: start_i is a single-cycle pulse taken only in IDLE;
// exit_i is level-held by the RCs until a cycle with pc_e_o=1 samples it;
// abort_i is taken in any non-IDLE state and overrides exit, branch and stall.
module pc_sequencer #(
    parameter int CNT_N_BITS   = 4,
    parameter int N_RC         = 4,
    parameter int DRAIN_CYCLES = 2,
    parameter int CYC_W        = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic                       stall_i,
    input  logic [N_RC-1:0]            exit_i,
    input  logic [N_RC-1:0]            br_req_i,
    input  logic [N_RC*CNT_N_BITS-1:0] br_add_i,
    output logic                       pc_restart_o,
    output logic                       pc_e_o,
    output logic                       br_req_o,
    output logic [CNT_N_BITS-1:0]      br_add_o,
    output logic                       rcs_en_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       aborted_o,
    output logic [CYC_W-1:0]           cycles_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Last value of the drain counter before moving to DONE.
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        drain_cnt_q, drain_cnt_d;
    logic [CYC_W-1:0]  cycles_q, cycles_d;
    logic              aborted_q, aborted_d;

    logic [CNT_N_BITS-1:0] win_add;
    logic                  any_br;
    logic                  run_go;
    logic                  exit_take;
    logic                  abort_take;

    // Priority pick of the branch target: scanning from the top lets the
    // lowest requesting index overwrite everyone above it.
    always_comb begin
        win_add = '0;
        for (int k = N_RC - 1; k >= 0; k--) begin
            if (br_req_i[k]) begin
                win_add = br_add_i[k*CNT_N_BITS +: CNT_N_BITS];
            end
        end
    end

    assign any_br     = |br_req_i;
    assign abort_take = abort_i && (state_q != IDLE);
    // The PC advances only in RUN, without stall, and when no abort is pending.
    assign run_go     = (state_q == RUN) && !stall_i && !abort_i;
    // EXIT is only sampled on cycles where the PC is enabled.
    assign exit_take  = run_go && (|exit_i);

    // State and bookkeeping registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            cycles_q    <= '0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            cycles_q    <= cycles_d;
            aborted_q   <= aborted_d;
        end
    end

    // Next-state, drain counter, run-cycle counter and abort flag.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = '0;
        cycles_d    = cycles_q;
        aborted_d   = abort_take;
        case (state_q)
            IDLE: begin
                // Start wins over a simultaneous abort, which IDLE ignores.
                if (start_i) begin
                    state_d  = RUN;
                    cycles_d = '0;
                end
            end
            RUN: begin
                // Stall cycles count; the counter sticks at all-ones.
                if (cycles_q != '1) begin
                    cycles_d = cycles_q + CYC_W'(1);
                end
                if (abort_i) begin
                    state_d = IDLE;
                end else if (exit_take) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Fixed-length drain; stall has no effect here.
                drain_cnt_d = drain_cnt_q + 4'd1;
                if (abort_i) begin
                    state_d = IDLE;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Combinational outputs from state and current inputs.
    always_comb begin
        pc_restart_o = 1'b0;
        pc_e_o       = 1'b0;
        br_req_o     = 1'b0;
        br_add_o     = '0;
        rcs_en_o     = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            IDLE: begin
                pc_restart_o = 1'b1;
            end
            RUN: begin
                busy_o   = 1'b1;
                pc_e_o   = run_go;
                rcs_en_o = run_go;
                // An EXIT taken this cycle suppresses any branch.
                br_req_o = any_br && run_go && !exit_take;
                br_add_o = win_add;
            end
            DRAIN: begin
                busy_o = 1'b1;
            end
            DONE: begin
                busy_o = 1'b1;
                done_o = !abort_i;
            end
            default: begin
                pc_restart_o = 1'b1;
            end
        endcase
    end

    assign aborted_o = aborted_q;
    assign cycles_o  = cycles_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomised bench for pc_sequencer: expected output vectors are
// queued as stimulus is driven and compared at the following falling edge.
module tb_pc_sequencer;

  localparam int W  = 4;
  localparam int NR = 4;

  logic              clk_i;
  logic              rst_ni;
  logic              start_i;
  logic              abort_i;
  logic              stall_i;
  logic [NR-1:0]     exit_i;
  logic [NR-1:0]     br_req_i;
  logic [NR*W-1:0]   br_add_i;
  logic              pc_restart_o;
  logic              pc_e_o;
  logic              br_req_o;
  logic [W-1:0]      br_add_o;
  logic              rcs_en_o;
  logic              busy_o;
  logic              done_o;
  logic              aborted_o;
  logic [31:0]       cycles_o;

  logic [10:0]       out_vec;
  logic [10:0]       exp_q[$];
  int                n_vec;
  int                n_err;

  pc_sequencer #(
    .CNT_N_BITS   (4),
    .N_RC         (4),
    .DRAIN_CYCLES (2),
    .CYC_W        (32)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .stall_i      (stall_i),
    .exit_i       (exit_i),
    .br_req_i     (br_req_i),
    .br_add_i     (br_add_i),
    .pc_restart_o (pc_restart_o),
    .pc_e_o       (pc_e_o),
    .br_req_o     (br_req_o),
    .br_add_o     (br_add_o),
    .rcs_en_o     (rcs_en_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .aborted_o    (aborted_o),
    .cycles_o     (cycles_o)
  );

  assign out_vec = {pc_restart_o, pc_e_o, br_req_o, br_add_o, rcs_en_o, busy_o, done_o, aborted_o};

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [10:0] ev(input logic rs, input logic pe, input logic bq,
                                     input logic [3:0] ba, input logic rc, input logic bz,
                                     input logic dn, input logic ab);
    return {rs, pe, bq, ba, rc, bz, dn, ab};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at posedge+1, queue the expectation, compare at negedge.
  task automatic step(input string tag, input logic s, input logic a, input logic st,
                      input logic [3:0] ex, input logic [3:0] br, input logic [15:0] add,
                      input logic [10:0] e);
    logic [10:0] want;
    start_i  = s;
    abort_i  = a;
    stall_i  = st;
    exit_i   = ex;
    br_req_i = br;
    br_add_i = add;
    exp_q.push_back(e);
    @(negedge clk_i);
    want = exp_q.pop_front();
    check(tag, {21'b0, out_vec}, {21'b0, want});
    @(posedge clk_i);
    #1;
  endtask

  logic [10:0] v_i, v_ia, v_r, v_d, v_dn;

  initial begin
    n_vec = 0;
    n_err = 0;
    v_i  = ev(1, 0, 0, 4'h0, 0, 0, 0, 0);
    v_ia = ev(1, 0, 0, 4'h0, 0, 0, 0, 1);
    v_r  = ev(0, 1, 0, 4'h0, 1, 1, 0, 0);
    v_d  = ev(0, 0, 0, 4'h0, 0, 1, 0, 0);
    v_dn = ev(0, 0, 0, 4'h0, 0, 1, 1, 0);

    rst_ni = 1'b0; start_i = 0; abort_i = 0; stall_i = 0;
    exit_i = '0; br_req_i = '0; br_add_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_out", {21'b0, out_vec}, {21'b0, v_i});
    check("reset_cyc", cycles_o, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Normal run: branch in cycle 3, RC2 exit in cycle 5.
    step("a_start", 1, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_i);
    step("a_run1",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_r);
    step("a_run2",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_r);
    step("a_br",    0, 0, 0, 4'b0000, 4'b1010, 16'h9060, ev(0, 1, 1, 4'h6, 1, 1, 0, 0));
    step("a_run4",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_r);
    step("a_exit",  0, 0, 0, 4'b0100, 4'b0000, 16'h0000, v_r);
    step("a_drn1",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_d);
    step("a_drn2",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_d);
    step("a_done",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_dn);
    check("a_cyc", cycles_o, 32'd5);
    step("a_idle",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_i);

    // Stall over a pending branch+exit; start in RUN ignored; exit wins over branch.
    step("b_start", 1, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_i);
    step("b_st_ig", 1, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_r);
    for (int i = 0; i < 3; i++)
      step("b_stall", 0, 0, 1, 4'b0001, 4'b0001, 16'h0003, ev(0, 0, 0, 4'h3, 0, 1, 0, 0));
    step("b_exit",  0, 0, 0, 4'b0001, 4'b0001, 16'h0003, ev(0, 1, 0, 4'h3, 1, 1, 0, 0));
    step("b_drn1",  0, 0, 1, 4'b0000, 4'b0000, 16'h0000, v_d);
    step("b_drn2",  0, 0, 1, 4'b0000, 4'b0000, 16'h0000, v_d);
    step("b_done",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_dn);
    check("b_cyc", cycles_o, 32'd5);
    step("b_idle",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_i);

    // Abort during DRAIN, abort ignored in IDLE, start+abort in IDLE accepted.
    step("c_start", 1, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_i);
    step("c_exit",  0, 0, 0, 4'b1000, 4'b0000, 16'h0000, v_r);
    step("c_abort", 0, 1, 0, 4'b0000, 4'b0000, 16'h0000, v_d);
    step("c_abtd",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_ia);
    check("c_cyc_hold", cycles_o, 32'd1);
    step("c_ab_idl", 0, 1, 0, 4'b0000, 4'b0000, 16'h0000, v_i);
    step("c_st_ab", 1, 1, 0, 4'b0000, 4'b0000, 16'h0000, v_i);
    check("c_cyc_clr", cycles_o, 32'd0);
    step("c_run1",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_r);
    step("c_exit2", 0, 0, 0, 4'b0001, 4'b0000, 16'h0000, v_r);
    step("c_drn1",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_d);
    step("c_drn2",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_d);
    step("c_done",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_dn);
    check("c_cyc", cycles_o, 32'd2);
    step("c_idle",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_i);

    // Abort in RUN beats stall and exit.
    step("d_start", 1, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_i);
    step("d_abort", 0, 1, 1, 4'b1111, 4'b0000, 16'h0000, v_d);
    step("d_abtd",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_ia);
    step("d_idle",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_i);

    // Random branch patterns: lowest requesting RC supplies the target.
    step("e_start", 1, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_i);
    for (int i = 0; i < 12; i++) begin
      logic [3:0]  br;
      logic [15:0] add;
      logic [3:0]  tgt;
      logic [10:0] e;
      br  = 4'($urandom_range(0, 15));
      add = 16'($urandom_range(0, 65535));
      tgt = 4'h0;
      for (int k = 0; k < NR; k++) begin
        if (br[k]) begin
          tgt = add[k*4 +: 4];
          break;
        end
      end
      e = (br != 4'b0000) ? ev(0, 1, 1, tgt, 1, 1, 0, 0) : v_r;
      step("e_arb", 0, 0, 0, 4'b0000, br, add, e);
    end
    step("e_exit",  0, 0, 0, 4'b0010, 4'b0000, 16'h0000, v_r);
    step("e_drn1",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_d);
    step("e_drn2",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_d);
    step("e_done",  0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_dn);
    check("e_cyc", cycles_o, 32'd13);

    // Reset in the middle of RUN.
    step("f_start", 1, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_i);
    for (int i = 0; i < 7; i++)
      step("f_run", 0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_r);
    check("f_cyc7", cycles_o, 32'd7);
    rst_ni = 1'b0;
    #1;
    check("f_rst_out", {21'b0, out_vec}, {21'b0, v_i});
    check("f_rst_cyc", cycles_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    step("f_idle", 0, 0, 0, 4'b0000, 4'b0000, 16'h0000, v_i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
